// File: rtl/mips_defs.sv
// rtl/mips_defs.sv - opcode, funct, ALU-op, FSM state and control-word definitions for the multicycle MIPS core
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2a;

    typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} aluop_t;
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_fn_t;
    typedef enum logic [1:0] {PC_ALU, PC_AOUT, PC_JUMP} pc_src_t;
    typedef enum logic [1:0] {SRCB_B, SRCB_FOUR, SRCB_IMM, SRCB_IMMSH} srcb_t;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC, S_RWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP
    } state_t;

    typedef struct packed {
        logic    pc_we;
        pc_src_t pc_src;
        logic    ir_we;
        logic    ab_we;
        logic    ao_we;
        logic    mdr_we;
        logic    rf_we;
        logic    rf_dst_rd;
        logic    rf_src_mdr;
        logic    src_a_reg;
        srcb_t   src_b;
        aluop_t  alu_op;
        logic    mem_req;
        logic    mem_we;
        logic    iord;
        logic    retired;
    } ctl_t;

    // Unknown R-type functs fall back to add so the ALU output is always defined.
    function automatic alu_fn_t alu_ctl(input aluop_t op, input logic [5:0] funct);
        alu_fn_t f;
        f = ALU_ADD;
        case (op)
            ALUOP_ADD: f = ALU_ADD;
            ALUOP_SUB: f = ALU_SUB;
            default: begin
                case (funct)
                    FN_ADD:  f = ALU_ADD;
                    FN_SUB:  f = ALU_SUB;
                    FN_AND:  f = ALU_AND;
                    FN_OR:   f = ALU_OR;
                    FN_SLT:  f = ALU_SLT;
                    default: f = ALU_ADD;
                endcase
            end
        endcase
        return f;
    endfunction

endpackage

// File: rtl/control_multi.sv
// rtl/control_multi.sv - multicycle control FSM: sequences fetch/decode/execute and the memory handshake
module control_multi
    import mips_defs::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] opcode_i,
    input  logic       mem_ready_i,
    input  logic       alu_zero_i,
    output ctl_t       ctl_o
);

    state_t state_q, state_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        ctl_o   = '0;
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                ctl_o.mem_req = 1'b1;
                ctl_o.src_b   = SRCB_FOUR;
                if (mem_ready_i) begin
                    ctl_o.ir_we  = 1'b1;
                    ctl_o.pc_we  = 1'b1;
                    ctl_o.pc_src = PC_ALU;
                    state_d      = S_DECODE;
                end
            end
            S_DECODE: begin
                ctl_o.ab_we = 1'b1;
                ctl_o.ao_we = 1'b1;
                ctl_o.src_b = SRCB_IMMSH;
                case (opcode_i)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        ctl_o.retired = 1'b1;
                        state_d       = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ctl_o.src_a_reg = 1'b1;
                ctl_o.src_b     = SRCB_IMM;
                ctl_o.ao_we     = 1'b1;
                state_d         = (opcode_i == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                ctl_o.mem_req = 1'b1;
                ctl_o.iord    = 1'b1;
                if (mem_ready_i) begin
                    ctl_o.mdr_we = 1'b1;
                    state_d      = S_MEMWB;
                end
            end
            S_MEMWB: begin
                ctl_o.rf_we      = 1'b1;
                ctl_o.rf_src_mdr = 1'b1;
                ctl_o.retired    = 1'b1;
                state_d          = S_FETCH;
            end
            S_MEMWR: begin
                ctl_o.mem_req = 1'b1;
                ctl_o.mem_we  = 1'b1;
                ctl_o.iord    = 1'b1;
                if (mem_ready_i) begin
                    ctl_o.retired = 1'b1;
                    state_d       = S_FETCH;
                end
            end
            S_EXEC: begin
                ctl_o.src_a_reg = 1'b1;
                ctl_o.src_b     = SRCB_B;
                ctl_o.alu_op    = ALUOP_FUNCT;
                ctl_o.ao_we     = 1'b1;
                state_d         = S_RWB;
            end
            S_RWB: begin
                ctl_o.rf_we     = 1'b1;
                ctl_o.rf_dst_rd = 1'b1;
                ctl_o.retired   = 1'b1;
                state_d         = S_FETCH;
            end
            S_ADDIEX: begin
                ctl_o.src_a_reg = 1'b1;
                ctl_o.src_b     = SRCB_IMM;
                ctl_o.ao_we     = 1'b1;
                state_d         = S_ADDIWB;
            end
            S_ADDIWB: begin
                ctl_o.rf_we   = 1'b1;
                ctl_o.retired = 1'b1;
                state_d       = S_FETCH;
            end
            S_BRANCH: begin
                ctl_o.src_a_reg = 1'b1;
                ctl_o.src_b     = SRCB_B;
                ctl_o.alu_op    = ALUOP_SUB;
                ctl_o.pc_we     = alu_zero_i;
                ctl_o.pc_src    = PC_AOUT;
                ctl_o.retired   = 1'b1;
                state_d         = S_FETCH;
            end
            S_JUMP: begin
                ctl_o.pc_we   = 1'b1;
                ctl_o.pc_src  = PC_JUMP;
                ctl_o.retired = 1'b1;
                state_d       = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: rtl/mips_multi_cycle.sv
// rtl/mips_multi_cycle.sv - multicycle MIPS datapath with shared ALU and req/ready memory port
// Optional MIPS_MULTI_PERF_EN adds cycle_count/retire_count outputs.
module mips_multi_cycle
    import mips_defs::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ready,
    output logic [31:0]           pc_out,
    output logic                  instr_retired
`ifdef MIPS_MULTI_PERF_EN
    ,
    output logic [31:0]           cycle_count,
    output logic [31:0]           retire_count
`endif
);

    ctl_t        ctl;
    logic [31:0] pc_q, pc_d, ir_q, a_q, b_q, ao_q, mdr_q;
    logic [31:0] rf_q [0:31];
    logic [31:0] sext, alu_a, alu_b, alu_y, rs_val, rt_val, addr_full, rf_wdata;
    logic [4:0]  rf_waddr;
    logic        alu_zero;
    logic        unused_shamt;

    control_multi u_ctl (
        .clk_i       (clk),
        .rst_i       (reset),
        .opcode_i    (ir_q[31:26]),
        .mem_ready_i (mem_ready),
        .alu_zero_i  (alu_zero),
        .ctl_o       (ctl)
    );

    assign sext   = {{16{ir_q[15]}}, ir_q[15:0]};
    assign rs_val = (ir_q[25:21] == 5'd0) ? 32'd0 : rf_q[ir_q[25:21]];
    assign rt_val = (ir_q[20:16] == 5'd0) ? 32'd0 : rf_q[ir_q[20:16]];
    assign unused_shamt = ^ir_q[10:6];

    always_comb begin
        alu_a = ctl.src_a_reg ? a_q : pc_q;
        case (ctl.src_b)
            SRCB_B:     alu_b = b_q;
            SRCB_FOUR:  alu_b = 32'd4;
            SRCB_IMM:   alu_b = sext;
            default:    alu_b = {sext[29:0], 2'b00};
        endcase
        case (alu_ctl(ctl.alu_op, ir_q[5:0]))
            ALU_SUB: alu_y = alu_a - alu_b;
            ALU_AND: alu_y = alu_a & alu_b;
            ALU_OR:  alu_y = alu_a | alu_b;
            ALU_SLT: alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_y = alu_a + alu_b;
        endcase
    end
    assign alu_zero = (alu_y == 32'd0);

    always_comb begin
        case (ctl.pc_src)
            PC_AOUT: pc_d = ao_q;
            PC_JUMP: pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
            default: pc_d = alu_y;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q  <= RESET_PC;
            ir_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            ao_q  <= '0;
            mdr_q <= '0;
        end else begin
            if (ctl.pc_we)  pc_q  <= pc_d;
            if (ctl.ir_we)  ir_q  <= mem_rdata;
            if (ctl.ab_we)  a_q   <= rs_val;
            if (ctl.ab_we)  b_q   <= rt_val;
            if (ctl.ao_we)  ao_q  <= alu_y;
            if (ctl.mdr_we) mdr_q <= mem_rdata;
        end
    end

    // Register file is deliberately not reset; $0 is never written and reads back as zero.
    assign rf_waddr = ctl.rf_dst_rd ? ir_q[15:11] : ir_q[20:16];
    assign rf_wdata = ctl.rf_src_mdr ? mdr_q : ao_q;
    always_ff @(posedge clk) begin
        if (ctl.rf_we && rf_waddr != 5'd0) rf_q[rf_waddr] <= rf_wdata;
    end

    // Request is masked during reset so an in-flight access is dropped at once.
    assign mem_req       = ctl.mem_req & ~reset;
    assign mem_we        = ctl.mem_we & ~reset;
    assign addr_full     = ctl.iord ? ao_q : pc_q;
    assign mem_addr      = addr_full[ADDR_WIDTH-1:0];
    assign mem_wdata     = b_q;
    assign pc_out        = pc_q;
    assign instr_retired = ctl.retired;

`ifdef MIPS_MULTI_PERF_EN
    logic [31:0] cycle_q, retire_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q  <= '0;
            retire_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (instr_retired) retire_q <= retire_q + 32'd1;
        end
    end
    assign cycle_count  = cycle_q;
    assign retire_count = retire_q;
`endif

endmodule

// File: tb/tb_mips_multi_cycle.sv
// tb/tb_mips_multi_cycle.sv - directed self-checking bench for mips_multi_cycle with a wait-state memory model
module tb_mips_multi_cycle;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req, mem_we, mem_ready, instr_retired;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;
`ifdef MIPS_MULTI_PERF_EN
    logic [31:0] cycle_count, retire_count;
`endif

    always #5 clk = ~clk;

    mips_multi_cycle #(.RESET_PC(32'h0000_0100), .ADDR_WIDTH(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ready     (mem_ready),
        .pc_out        (pc_out),
        .instr_retired (instr_retired)
`ifdef MIPS_MULTI_PERF_EN
        ,
        .cycle_count   (cycle_count),
        .retire_count  (retire_count)
`endif
    );

    logic [31:0] prog [0:127];
    logic [31:0] dm   [0:127];
    logic        dv   [0:127];
    int          waits = 0;
    int          wcnt = 0;
    int          ret_cnt = 0;
    int          wr_cnt = 0;
    int          viol = 0;
    logic [31:0] wr_addr, wr_data, hold_addr, hold_wdata;
    logic        hold_we;
    logic [6:0]  widx;
    int          n_chk = 0;
    int          n_fail = 0;

    assign widx      = mem_addr[8:2];
    assign mem_rdata = dv[widx] ? dm[widx] : prog[widx];
    assign mem_ready = mem_req && (wcnt >= waits);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt <= 0;
            for (int i = 0; i < 128; i++) dv[i] <= 1'b0;
        end else begin
            wcnt <= (mem_req && !mem_ready) ? wcnt + 1 : 0;
            if (mem_req && mem_ready && mem_we) begin
                dm[widx] <= mem_wdata;
                dv[widx] <= 1'b1;
                wr_cnt   <= wr_cnt + 1;
                wr_addr  <= mem_addr;
                wr_data  <= mem_wdata;
            end
            if (instr_retired) ret_cnt <= ret_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (!reset && mem_req) begin
            if (wcnt == 0) begin
                hold_addr  = mem_addr;
                hold_we    = mem_we;
                hold_wdata = mem_wdata;
            end else if (mem_addr !== hold_addr || mem_we !== hold_we ||
                         (mem_we && mem_wdata !== hold_wdata)) begin
                viol = viol + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_ret(input int n, input int budget, output int cycles);
        int start;
        start  = ret_cnt;
        cycles = 0;
        while ((ret_cnt - start) < n && cycles < budget) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        chk("retire_timeout", ((ret_cnt - start) >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    logic [31:0] exp_r [4] = '{32'hFFFF_FFFE, 32'd1, 32'd5, 32'd7};
    int          c, w0;

    initial begin
        for (int i = 0; i < 128; i++) prog[i] = 32'h0;
        prog[64] = 32'h2001_0005;  // addi $1,$0,5
        prog[65] = 32'h2002_0007;  // addi $2,$0,7
        prog[66] = 32'h0022_1820;  // add  $3,$1,$2
        prog[67] = 32'hAC03_0040;  // sw   $3,0x40($0)
        prog[68] = 32'h8C04_0040;  // lw   $4,0x40($0)
        prog[69] = 32'hAC04_0044;  // sw   $4,0x44($0)
        prog[70] = 32'hFC21_FFFF;  // opcode 0x3F
        prog[71] = 32'h0022_0020;  // add  $0,$1,$2
        prog[72] = 32'hAC00_0048;  // sw   $0,0x48($0)
        prog[73] = 32'hAC01_004C;  // sw   $1,0x4C($0)
        prog[74] = 32'h0022_2822;  // sub  $5,$1,$2
        prog[75] = 32'h00A1_302A;  // slt  $6,$5,$1
        prog[76] = 32'h0022_3824;  // and  $7,$1,$2
        prog[77] = 32'h0022_4025;  // or   $8,$1,$2
        prog[78] = 32'hAC05_0050;
        prog[79] = 32'hAC06_0054;
        prog[80] = 32'hAC07_0058;
        prog[81] = 32'hAC08_005C;
        prog[82] = 32'h0800_0004;  // j 0x10
        prog[4]  = 32'h1021_0002;  // beq $1,$1,+2 (taken)
        prog[7]  = 32'h1022_0005;  // beq $1,$2,+5 (not taken)
        prog[8]  = 32'h0800_0040;  // j 0x100

        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_pc", pc_out, 32'h100);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_retire", {31'd0, instr_retired}, 32'd0);
`ifdef MIPS_MULTI_PERF_EN
        chk("rst_cycles", cycle_count, 32'd0);
        chk("rst_retires", retire_count, 32'd0);
`endif
        reset = 1'b0;
        #1;
        chk("first_req", {31'd0, mem_req}, 32'd1);
        chk("first_addr", mem_addr, 32'h100);

        run_ret(5, 200, c);
        chk("prog0_cycles", c, 32'd21);
        chk("sw_addr", wr_addr, 32'h40);
        chk("sw_data", wr_data, 32'd12);
        chk("wr_count", wr_cnt, 32'd1);
        chk("pc_after_lw", pc_out, 32'h114);
`ifdef MIPS_MULTI_PERF_EN
        chk("perf_cycles", cycle_count, 32'd21);
        chk("perf_retires", retire_count, 32'd5);
`endif

        run_ret(1, 50, c);
        chk("sw_cycles", c, 32'd4);
        chk("lw_result_addr", wr_addr, 32'h44);
        chk("lw_result_data", wr_data, 32'd12);

        w0 = wr_cnt;
        run_ret(1, 50, c);
        chk("nop_cycles", c, 32'd2);
        chk("nop_pc", pc_out, 32'h11C);
        run_ret(1, 50, c);
        chk("add0_cycles", c, 32'd4);
        chk("no_write", wr_cnt - w0, 32'd0);
        run_ret(1, 50, c);
        chk("r0_data", wr_data, 32'd0);
        run_ret(1, 50, c);
        chk("r1_kept", wr_data, 32'd5);

        run_ret(4, 100, c);
        chk("rtype4_cycles", c, 32'd16);
        for (int i = 0; i < 4; i++) begin
            run_ret(1, 50, c);
            chk("alu_addr", wr_addr, 32'h50 + 32'(4 * i));
            chk("alu_data", wr_data, exp_r[i]);
        end

        run_ret(1, 50, c);
        chk("j_cycles", c, 32'd3);
        chk("j_pc", pc_out, 32'h10);
        run_ret(1, 50, c);
        chk("beq_t_cycles", c, 32'd3);
        chk("beq_t_pc", pc_out, 32'h1C);
        run_ret(1, 50, c);
        chk("beq_nt_pc", pc_out, 32'h20);
        run_ret(1, 50, c);
        chk("j_hi_pc", pc_out, 32'h100);
        #1;
        chk("j_hi_fetch", mem_addr, 32'h100);

        @(negedge clk);
        reset = 1'b1;
        waits = 3;
        @(negedge clk);
        reset = 1'b0;
        run_ret(5, 400, c);
        chk("wait_cycles", c, 32'd42);
        chk("wait_sw_data", wr_data, 32'd12);
        run_ret(1, 100, c);
        chk("wait_sw_cycles", c, 32'd10);
        chk("wait_lw_data", wr_data, 32'd12);
        chk("stable", viol, 32'd0);

        w0 = wr_cnt;
        repeat (2) @(negedge clk);
        chk("mid_fetch_req", {31'd0, mem_req}, 32'd1);
        chk("mid_fetch_addr", mem_addr, 32'h118);
        reset = 1'b1;
        #1;
        chk("async_pc", pc_out, 32'h100);
        chk("async_req", {31'd0, mem_req}, 32'd0);
`ifdef MIPS_MULTI_PERF_EN
        chk("perf_clr_cyc", cycle_count, 32'd0);
        chk("perf_clr_ret", retire_count, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("refetch_addr", mem_addr, 32'h100);
        chk("no_write_rst", wr_cnt - w0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
